// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the EX-stage multiply/divide unit.
// Ports: none (package). Imported by div_mul_step and ex_muldiv_unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } muldiv_state_e;

    // RV32M/RV64M funct3 encodings
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    function automatic logic is_signed_rs1(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_rs2(muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(muldiv_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/div_mul_step.sv
// Combinational radix step: RADIX_BITS chained add-shift (multiply) or
// restoring subtract-shift (divide) stages on a 2*XLEN accumulator.
// Ports: i_is_div selects divide; i_acc current accumulator
//        ({hi,lo}: mul = {partial, multiplier}, div = {remainder, dividend/quotient});
//        i_b multiplicand or divisor magnitude; o_acc accumulator after the step.
module div_mul_step
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_b,
    output logic [2*XLEN-1:0] o_acc
);

    logic [2*XLEN-1:0] w_acc [RADIX_BITS+1];

    assign w_acc[0] = i_acc;
    assign o_acc    = w_acc[RADIX_BITS];

    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_stage
        logic [XLEN:0] w_sum;
        logic [XLEN:0] w_shl;
        logic [XLEN:0] w_trial;

        assign w_sum = {1'b0, w_acc[g][2*XLEN-1:XLEN]}
                     + (w_acc[g][0] ? {1'b0, i_b} : '0);
        assign w_shl = {w_acc[g][2*XLEN-1:XLEN], w_acc[g][XLEN-1]};
        // The partial remainder is always below the divisor, so an
        // (XLEN+1)-bit difference never wraps: its MSB is the borrow.
        assign w_trial = w_shl - {1'b0, i_b};

        always_comb begin
            w_acc[g+1] = {w_sum, w_acc[g][XLEN-1:1]};
            if (i_is_div) begin
                if (w_trial[XLEN])
                    w_acc[g+1] = {w_shl[XLEN-1:0], w_acc[g][XLEN-2:0], 1'b0};
                else
                    w_acc[g+1] = {w_trial[XLEN-1:0], w_acc[g][XLEN-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV M-extension unit for EX: all eight ops, owns the M-op stall.
// Ports: i_clk, i_reset (sync, active-high), i_start, i_funct3, i_rs1_data,
//        i_rs2_data, i_kill -> o_stall, o_done (1-cycle), o_result, o_busy.
// Optional: MULDIV_RESULT_REUSE_EN keeps the last full-path result for reuse.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_kill,
    output logic            o_stall,
    output logic            o_done,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int ITERS = XLEN / RADIX_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     r_state, w_next;
    muldiv_op_e        r_op, w_op;
    logic [XLEN-1:0]   r_a, r_b, r_m, r_result;
    logic [2*XLEN-1:0] r_acc, w_step, w_prod, w_fix;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_neg, r_sa;
    logic              w_go, w_dz, w_ovf, w_hit, w_fast;
    logic              w_sa, w_sb;
    logic [XLEN-1:0]   w_abs_a, w_abs_b, w_quo, w_rem, w_fast_res;

    // {rem,quo} for divides, full product for multiplies
    function automatic logic [XLEN-1:0] sel_res(muldiv_op_e op,
                                                logic [2*XLEN-1:0] v);
        if (is_div(op))
            return op[1] ? v[2*XLEN-1:XLEN] : v[XLEN-1:0];
        return (op == OP_MUL) ? v[XLEN-1:0] : v[2*XLEN-1:XLEN];
    endfunction

    assign w_op  = muldiv_op_e'(i_funct3);
    assign w_go  = (r_state == S_IDLE) & i_start & ~i_kill;
    assign w_dz  = is_div(w_op) & (i_rs2_data == '0);
    assign w_ovf = (w_op == OP_DIV || w_op == OP_REM)
                 & (i_rs1_data == MIN) & (i_rs2_data == '1);
    assign w_fast = w_dz | w_ovf | w_hit;

`ifdef MULDIV_RESULT_REUSE_EN
    logic              r_tag_vld, r_tag_div;
    logic [1:0]        r_tag_sgn;
    logic [XLEN-1:0]   r_tag_a, r_tag_b;
    logic [2*XLEN-1:0] r_last;

    // MUL low half is signedness-independent, so it matches any mul tag
    assign w_hit = r_tag_vld
                 & (i_rs1_data == r_tag_a) & (i_rs2_data == r_tag_b)
                 & (is_div(w_op) == r_tag_div)
                 & (({is_signed_rs1(w_op), is_signed_rs2(w_op)} == r_tag_sgn)
                    | (w_op == OP_MUL));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tag_vld <= 1'b0;
            r_tag_div <= 1'b0;
            r_tag_sgn <= '0;
            r_tag_a   <= '0;
            r_tag_b   <= '0;
            r_last    <= '0;
        end else if (i_kill) begin
            r_tag_vld <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_tag_vld <= 1'b1;
            r_tag_div <= is_div(r_op);
            r_tag_sgn <= {is_signed_rs1(r_op), is_signed_rs2(r_op)};
            r_tag_a   <= r_a;
            r_tag_b   <= r_b;
            r_last    <= w_fix;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_fast_res = '0;
        if (w_dz)
            w_fast_res = is_rem(w_op) ? i_rs1_data : '1;
        else if (w_ovf)
            w_fast_res = is_rem(w_op) ? '0 : MIN;
`ifdef MULDIV_RESULT_REUSE_EN
        else if (w_hit)
            w_fast_res = sel_res(w_op, r_last);
`endif
    end

    assign w_sa    = is_signed_rs1(r_op) & r_a[XLEN-1];
    assign w_sb    = is_signed_rs2(r_op) & r_b[XLEN-1];
    assign w_abs_a = w_sa ? -r_a : r_a;
    assign w_abs_b = w_sb ? -r_b : r_b;

    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_fix  = is_div(r_op) ? {w_rem, w_quo} : w_prod;

    div_mul_step #(
        .XLEN      (XLEN),
        .RADIX_BITS(RADIX_BITS)
    ) u_step (
        .i_is_div(is_div(r_op)),
        .i_acc   (r_acc),
        .i_b     (r_m),
        .o_acc   (w_step)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        o_busy  = (r_state != S_IDLE);
        o_done  = (r_state == S_DONE);
        o_stall = (i_start & (r_state == S_IDLE))
                | (o_busy & (r_state != S_DONE));
        case (r_state)
            S_IDLE:  if (w_go) w_next = w_fast ? S_DONE : S_PREP;
            S_PREP:  w_next = S_ITER;
            S_ITER:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_kill && r_state != S_IDLE) w_next = S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op     <= OP_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_m      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_sa     <= 1'b0;
            r_result <= '0;
        end else if (w_go) begin
            r_op <= w_op;
            r_a  <= i_rs1_data;
            r_b  <= i_rs2_data;
            if (w_fast) r_result <= w_fast_res;
        end else if (!i_kill) begin
            case (r_state)
                S_PREP: begin
                    r_acc <= {{XLEN{1'b0}}, w_abs_a};
                    r_m   <= w_abs_b;
                    r_neg <= w_sa ^ w_sb;
                    r_sa  <= w_sa;
                    r_cnt <= CNT_W'(ITERS);
                end
                S_ITER: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX:   r_result <= sel_res(r_op, w_fix);
                default: ;
            endcase
        end
    end

    assign o_result = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomised scoreboard bench for ex_muldiv_unit with an arithmetic model.
module tb_ex_muldiv_unit;

    parameter int XLEN       = 32;
    parameter int RADIX_BITS = 1;

    localparam int ITERS = XLEN / RADIX_BITS;
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2,
                           F_MULHU = 3'd3, F_DIV = 3'd4, F_DIVU = 3'd5,
                           F_REM = 3'd6, F_REMU = 3'd7;

    logic            clk = 1'b0;
    logic            i_reset, i_start, i_kill;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1, i_rs2;
    logic            o_stall, o_done, o_busy;
    logic [XLEN-1:0] o_result;

    ex_muldiv_unit #(.XLEN(XLEN), .RADIX_BITS(RADIX_BITS)) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_funct3  (i_funct3),
        .i_rs1_data(i_rs1),
        .i_rs2_data(i_rs2),
        .i_kill    (i_kill),
        .o_stall   (o_stall),
        .o_done    (o_done),
        .o_result  (o_result),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        int              t0;
        int              lat;
    } exp_t;

    exp_t            sb_q[$];
    exp_t            e;
    int              n_checks = 0;
    int              n_fail = 0;
    logic [XLEN-1:0] last_res = '0;

    // reference model of the reuse store: last full-path op
    logic            m_vld = 1'b0;
    logic [2:0]      m_f3;
    logic [XLEN-1:0] m_a, m_b;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_res(logic [2:0] f3,
                                                logic [XLEN-1:0] a,
                                                logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ua, ub, sa, sb, p;
        ua = {{XLEN{1'b0}}, a};
        ub = {{XLEN{1'b0}}, b};
        sa = {{XLEN{a[XLEN-1]}}, a};
        sb = {{XLEN{b[XLEN-1]}}, b};
        case (f3)
            F_MUL:    begin p = ua * ub; return p[XLEN-1:0]; end
            F_MULH:   begin p = sa * sb; return p[2*XLEN-1:XLEN]; end
            F_MULHSU: begin p = sa * ub; return p[2*XLEN-1:XLEN]; end
            F_MULHU:  begin p = ua * ub; return p[2*XLEN-1:XLEN]; end
            F_DIV: begin
                if (b == '0) return '1;
                if (a == MIN && b == '1) return MIN;
                return $signed(a) / $signed(b);
            end
            F_DIVU:   return (b == '0) ? '1 : a / b;
            F_REM: begin
                if (b == '0) return a;
                if (a == MIN && b == '1) return '0;
                return $signed(a) % $signed(b);
            end
            default:  return (b == '0) ? a : a % b;
        endcase
    endfunction

    // 0 unsigned, 2 rs1-signed only, 3 both signed
    function automatic int sclass(logic [2:0] f3);
        if (f3[2]) return f3[0] ? 0 : 3;
        if (f3 == F_MULH) return 3;
        if (f3 == F_MULHSU) return 2;
        return 0;
    endfunction

    function automatic logic reuse_hit(logic [2:0] f3,
                                       logic [XLEN-1:0] a,
                                       logic [XLEN-1:0] b);
`ifdef MULDIV_RESULT_REUSE_EN
        return m_vld && a == m_a && b == m_b && f3[2] == m_f3[2]
            && (sclass(f3) == sclass(m_f3) || f3 == F_MUL);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_lat(logic [2:0] f3,
                                   logic [XLEN-1:0] a,
                                   logic [XLEN-1:0] b);
        if (f3[2] && b == '0) return 1;
        if ((f3 == F_DIV || f3 == F_REM) && a == MIN && b == '1) return 1;
        if (reuse_hit(f3, a, b)) return 1;
        return ITERS + 3;
    endfunction

    always @(negedge clk) begin
        if (!i_reset && o_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1, required 0");
            end else begin
                e = sb_q.pop_front();
                check("result", 64'(o_result), 64'(e.res));
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
                check("stall_in_done", 64'(o_stall), 64'(0));
            end
        end
    end

    task automatic issue(logic [2:0] f3, logic [XLEN-1:0] a,
                         logic [XLEN-1:0] b, bit push);
        exp_t x;
        @(negedge clk);
        i_funct3 = f3;
        i_rs1    = a;
        i_rs2    = b;
        i_start  = 1'b1;
        if (push) begin
            x.res = ref_res(f3, a, b);
            x.t0  = cyc;
            x.lat = ref_lat(f3, a, b);
            sb_q.push_back(x);
            last_res = x.res;
            if (x.lat == ITERS + 3) begin
                m_vld = 1'b1;
                m_f3  = f3;
                m_a   = a;
                m_b   = b;
            end
        end
        #1;
        if (!i_kill) check("stall_on_start", 64'(o_stall), 64'(1));
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < ITERS + 10 && sb_q.size() != 0; i++)
            @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got no done, required %0d pending",
                     sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        check("idle_busy", 64'(o_busy), 64'(0));
        check("idle_stall", 64'(o_stall), 64'(0));
    endtask

    task automatic run(logic [2:0] f3, logic [XLEN-1:0] a,
                       logic [XLEN-1:0] b);
        issue(f3, a, b, 1'b1);
        wait_done();
    endtask

    function automatic logic [XLEN-1:0] rnd();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 64'd1;
            2:       v = '1;
            3:       v = 64'(MIN);
            4:       v = 64'($urandom_range(0, 20));
            default: v = {$urandom(), $urandom()};
        endcase
        return v[XLEN-1:0];
    endfunction

    initial begin
        logic [2:0]      f3;
        logic [XLEN-1:0] a, b;
        int              kcyc;

        i_reset  = 1'b1;
        i_start  = 1'b0;
        i_kill   = 1'b0;
        i_funct3 = '0;
        i_rs1    = '0;
        i_rs2    = '0;
        repeat (3) @(negedge clk);
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_busy", 64'(o_busy), 64'(0));
        check("rst_result", 64'(o_result), 64'(0));
        check("rst_stall", 64'(o_stall), 64'(0));
        i_reset = 1'b0;

        run(F_DIV, XLEN'(100), XLEN'(-7));
        run(F_REM, XLEN'(100), XLEN'(-7));
        run(F_MULH, MIN, MIN);
        run(F_MULHU, '1, '1);
        run(F_MUL, '1, '1);
        run(F_DIVU, XLEN'(5), '0);
        run(F_REM, XLEN'(5), '0);
        run(F_DIV, MIN, '1);
        run(F_REM, MIN, '1);
        run(F_DIV, XLEN'(100), XLEN'(7));
        run(F_REM, XLEN'(100), XLEN'(7));
        run(F_MULHSU, XLEN'(-3), '1);

        // start pulses while busy must not disturb the op in flight
        issue(F_DIVU, XLEN'(1000), XLEN'(7), 1'b1);
        repeat (3) @(negedge clk);
        i_funct3 = F_MUL;
        i_rs1    = XLEN'(12345);
        i_start  = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done();

        // kill in the middle of ITER
        kcyc = (ITERS > 10) ? 10 : ITERS / 2;
        issue(F_DIV, XLEN'(1000), XLEN'(3), 1'b0);
        repeat (kcyc) @(negedge clk);
        i_kill = 1'b1;
        @(negedge clk);
        i_kill = 1'b0;
        m_vld  = 1'b0;
        check("kill_busy", 64'(o_busy), 64'(0));
        check("kill_stall", 64'(o_stall), 64'(0));
        check("kill_result", 64'(o_result), 64'(last_res));
        repeat (ITERS + 5) @(negedge clk);
        run(F_DIV, XLEN'(9), XLEN'(3));

        // kill together with start in IDLE: start ignored
        i_kill = 1'b1;
        issue(F_DIV, XLEN'(9), XLEN'(3), 1'b0);
        i_kill = 1'b0;
        m_vld  = 1'b0;
        check("killstart_busy", 64'(o_busy), 64'(0));
        repeat (3) @(negedge clk);
        run(F_REM, XLEN'(9), XLEN'(3));

        // reset in the middle of ITER
        issue(F_MULHU, rnd(), rnd(), 1'b0);
        repeat (5) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        check("midrst_done", 64'(o_done), 64'(0));
        check("midrst_busy", 64'(o_busy), 64'(0));
        check("midrst_result", 64'(o_result), 64'(0));
        check("midrst_stall", 64'(o_stall), 64'(0));
        i_reset  = 1'b0;
        m_vld    = 1'b0;
        last_res = '0;

        a = rnd();
        b = rnd();
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) > 2) begin
                a = rnd();
                b = rnd();
            end
            run(f3, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
